tile_renderer: RTL and testbench
================================

# tile_renderer

Pixel-pipeline stage directly downstream of the VGA timing generator. It turns the generator's `row`/`col`/`blank_N`/`HS`/`VS` stream into 24-bit RGB for the Centipede playfield. The playfield is a 40x30 grid of 8x8 two-bit-per-pixel tiles, each drawn at 2x scale (16x16 screen pixels), on a 640x480 screen. Tile indices come from an external synchronous tile RAM, pixel rows from an external synchronous pattern ROM, and colours from a 4-entry writable palette; sync and blank are delayed to match the pixel latency.

## Interface
Parameters:
- `LAT`, 5: pipeline depth in cycles, input sample to RGB out. Fixed by the structure below; exposed for benches only.
- `TILES_X`, 40: tiles per row. Tile address multiplier.

Ports:
- `CLOCK_100` in 1: single clock, shared with the timing generator.
- `reset` in 1: asynchronous, active-low reset. All state clears when low.
- `row` in 9: current pixel row, 0..480.
- `col` in 10: current pixel column, 0..640. Each value is held for 2 clocks.
- `blank_N` in 1: high in the active display region.
- `HS`, `VS` in 1: sync inputs, active-low pulse.
- `tile_addr` out 11: tile RAM read address, registered.
- `tile_data` in 8: tile index. Valid one cycle after `tile_addr`.
- `pat_addr` out 11: pattern ROM address {tile index, tile row[2:0]}, registered.
- `pat_data` in 16: one 8-pixel row. `[15:14]` is the leftmost pixel. Valid one cycle after `pat_addr`.
- `pal_we` in 1: palette write strobe.
- `pal_idx` in 2: palette entry to write.
- `pal_data` in 24: {R,G,B} value to write.
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: pixel colour.
- `HS_out`, `VS_out`, `blank_N_out` out 1: `HS`, `VS`, `blank_N` delayed by `LAT` cycles.

## Operation
- **Edge E (S0).** Register `row`, `col`, `blank_N`, `HS`, `VS`, plus `vis = blank_N && row<480 && col<640`.
- **Edge E+1 (S1).** `tile_addr <= vis ? row[8:4]*40 + col[9:4] : 0`.
  - Implement the multiply as (r<<5)+(r<<3). Maximum result is 1199, which fits in 11 bits.
  - Forward `row[3:1]`, `col[3:1]` and `vis`.
- **Edge E+2 (S2).** Tile RAM delivers `tile_data`. Register `pat_addr <= {tile_data, row[3:1]}` and forward `col[3:1]` and `vis`.
- **Edge E+3 (S3).** Pattern ROM delivers `pat_data`. Register the pattern word, `px = col[3:1]` and `vis`.
- **Edge E+4 (S4).** `code <= vis ? pat_data[15-2*px -: 2] : 0`. Forward `vis`.
- **Edge E+5 (S5).**
  - `{VGA_R,VGA_G,VGA_B} <= vis ? palette[code] : 24'h000000`.
  - `HS_out`, `VS_out` and `blank_N_out` leave a 5-deep shift chain.
- **Palette.**
  - Four 24-bit registers.
  - Reset values: 0 = 000000, 1 = FF0000, 2 = 00FF00, 3 = 0000FF.
  - When `pal_we` is high at an edge, `palette[pal_idx] <= pal_data`.
- **Code 0 is not special.** It is coloured through the palette like any other code.
- **No backpressure and no stalls.** One pixel is accepted every cycle, unconditionally.

## Timing
- Latency is exactly 5 cycles from input sample to RGB, and to `HS_out`/`VS_out`/`blank_N_out`, for every pixel.
- `col` is held for 2 clocks, so every screen pixel appears on 2 consecutive output cycles. Each tile pixel therefore spans 2 columns x 2 rows on screen.
- **Reset value of every output is 0:**
  - `VGA_R`, `VGA_G`, `VGA_B`, `tile_addr`, `pat_addr`
  - `HS_out`, `VS_out`, `blank_N_out`: these output 0 for the first 5 cycles after reset release while the chain fills.
- **Reset asserted mid-frame** clears the pipeline and the palette immediately (asynchronous); the same-cycle outputs go to 0.
- **Palette write and lookup of the same entry at the same edge:** the S5 output uses the old value. The new value is used from the following edge.
- **Boundaries:**
  - `col==640` or `row==480` (counter limit values): `vis=0`, `tile_addr=0`, output black.
  - Last tile: row 479, col 639 → `tile_addr` 1199.
  - First tile: row 0, col 0 → `tile_addr` 0.
- **Blank region:** output is black regardless of RAM/ROM contents. RAM/ROM reads continue at address 0, which is harmless.

## Test plan
- **Reset and fill:** hold `reset` low, then release; drive `HS=1`, `VS=1`, `blank_N=1`. Outputs stay 0 until cycle 5, then `HS_out=1` and `VS_out=1` at cycle 5.
- **Address mapping:**
  - row 17, col 35 → `tile_addr` 42 one cycle after sample.
  - row 479, col 639 → 1199.
  - col 640 → 0.
- **Pixel extraction and latency:**
  - Setup: tile RAM returns 8'h05 and the pattern ROM models `pat_data` = 16'h1B00 for `pat_addr` {05, row[3:1]}.
  - row 2, col 0..15 → `pat_addr` {8'h05, 3'd1}.
  - Output colours:
    - cols 0-1: palette 0 (000000)
    - cols 2-3: palette 1 (FF0000)
    - cols 4-5: palette 2 (00FF00)
    - cols 6-7: palette 3 (0000FF)
    - cols 8-15: palette 0 (000000)
  - Each colour appears exactly 5 cycles after its input.
- **Blanking:** `blank_N=0` with ROM returning FFFF → RGB 000000 and `blank_N_out=0` 5 cycles later.
- **Palette write collision:** write `pal_idx=1`, `pal_data=123456` at the same edge that S5 looks up code 1 → FF0000 at that edge, 123456 from the next.
- **Reset mid-frame:** pull `reset` low during an active line → RGB 000000 with no clock; palette entry 1 returns to FF0000 afterwards.

Source files
------------

// File: rtl/tile_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tile_renderer
// Purpose  : Pixel stage behind the VGA timing generator. Maps each screen
//            pixel of the 640x480 playfield onto a 40x30 grid of 8x8
//            2-bpp tiles drawn at 2x scale. The tile index comes from an
//            external tile RAM and the pixel row from an external pattern
//            ROM. Each 2-bit code is coloured through a writable 4-entry
//            palette. Sync and blank are delayed to line up with RGB.
// Ports    : CLOCK_100            - pixel-pipeline clock
//            reset                - asynchronous, active-low reset
//            row / col            - current pixel position from the timing gen
//            blank_N / HS / VS    - active-region flag and active-low syncs
//            tile_addr/tile_data  - tile RAM read port (data one cycle later)
//            pat_addr / pat_data  - pattern ROM read port (data one cycle later)
//            pal_we/pal_idx/pal_data - palette write port
//            VGA_R/G/B            - 24-bit pixel colour, LAT cycles after sample
//            HS_out/VS_out/blank_N_out - inputs delayed by LAT cycles
// Revision : 1.0 - initial release
// ============================================================================
module tile_renderer #(
    parameter int LAT     = 5,
    parameter int TILES_X = 40
) (
    input  logic        CLOCK_100,
    input  logic        reset,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        blank_N,
    input  logic        HS,
    input  logic        VS,
    output logic [10:0] tile_addr,
    input  logic [7:0]  tile_data,
    output logic [10:0] pat_addr,
    input  logic [15:0] pat_data,
    input  logic        pal_we,
    input  logic [1:0]  pal_idx,
    input  logic [23:0] pal_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        HS_out,
    output logic        VS_out,
    output logic        blank_N_out
);

    localparam logic [23:0] c_PAL0_RST = 24'h000000;
    localparam logic [23:0] c_PAL1_RST = 24'hFF0000;
    localparam logic [23:0] c_PAL2_RST = 24'h00FF00;
    localparam logic [23:0] c_PAL3_RST = 24'h0000FF;

    // S0: sampled inputs. Only the bits used downstream are kept; the low
    // bits of row/col only matter for the visibility test.
    logic [8:1]     r_row0_q;
    logic [9:1]     r_col0_q;
    logic           r_vis0_q,  w_vis0_d;
    logic           r_hs0_q, r_vs0_q, r_blank0_q;

    // S1
    logic [10:0]    r_tile_addr_q, w_tile_addr_d;
    logic [2:0]     r_trow1_q;
    logic [2:0]     r_tcol1_q;
    logic           r_vis1_q;

    // S2
    logic [10:0]    r_pat_addr_q;
    logic [2:0]     r_tcol2_q;
    logic           r_vis2_q;

    // S3
    logic [15:0]    r_pat3_q;
    logic [2:0]     r_px3_q;
    logic           r_vis3_q;

    // S4
    logic [1:0]     r_code4_q, w_code4_d;
    logic           r_vis4_q;

    // S5
    logic [23:0]    r_rgb_q, w_rgb_d;

    // Sync/blank delay chain; bit LAT-1 is the output end.
    logic [LAT-1:0] r_hs_q, w_hs_d;
    logic [LAT-1:0] r_vs_q, w_vs_d;
    logic [LAT-1:0] r_blank_q, w_blank_d;

    logic [23:0]    r_pal_q [4];
    logic [23:0]    w_pal_d [4];

    // Row-of-tiles base address: tile row times TILES_X.
    logic [10:0]    w_trow_ext;
    logic [10:0]    w_row_base;

    assign w_trow_ext = {6'd0, r_row0_q[8:4]};

    generate
        if (TILES_X == 40) begin : g_mul_40
            // x*40 == x*32 + x*8; peak 29*40 = 1160 stays inside 11 bits.
            assign w_row_base = (w_trow_ext << 5) + (w_trow_ext << 3);
        end else begin : g_mul_generic
            assign w_row_base = w_trow_ext * 11'(TILES_X);
        end
    endgenerate

    always_comb begin
        w_vis0_d      = blank_N && (row < 9'd480) && (col < 10'd640);
        w_tile_addr_d = r_vis0_q ? (w_row_base + {5'd0, r_col0_q[9:4]}) : 11'd0;

        // Leftmost pixel sits in [15:14]; bit index 15-2*px is {~px,1}.
        w_code4_d     = r_vis3_q ? r_pat3_q[{~r_px3_q, 1'b1} -: 2] : 2'd0;

        w_rgb_d       = r_vis4_q ? r_pal_q[r_code4_q] : 24'h000000;

        w_hs_d        = {r_hs_q[LAT-2:0],    r_hs0_q};
        w_vs_d        = {r_vs_q[LAT-2:0],    r_vs0_q};
        w_blank_d     = {r_blank_q[LAT-2:0], r_blank0_q};

        for (int i = 0; i < 4; i++) begin
            w_pal_d[i] = r_pal_q[i];
        end
        if (pal_we) begin
            w_pal_d[pal_idx] = pal_data;
        end
    end

    always_ff @(posedge CLOCK_100 or negedge reset) begin
        if (!reset) begin
            r_row0_q      <= '0;
            r_col0_q      <= '0;
            r_vis0_q      <= 1'b0;
            r_hs0_q       <= 1'b0;
            r_vs0_q       <= 1'b0;
            r_blank0_q    <= 1'b0;
            r_tile_addr_q <= '0;
            r_trow1_q     <= '0;
            r_tcol1_q     <= '0;
            r_vis1_q      <= 1'b0;
            r_pat_addr_q  <= '0;
            r_tcol2_q     <= '0;
            r_vis2_q      <= 1'b0;
            r_pat3_q      <= '0;
            r_px3_q       <= '0;
            r_vis3_q      <= 1'b0;
            r_code4_q     <= '0;
            r_vis4_q      <= 1'b0;
            r_rgb_q       <= '0;
            r_hs_q        <= '0;
            r_vs_q        <= '0;
            r_blank_q     <= '0;
            r_pal_q[0]    <= c_PAL0_RST;
            r_pal_q[1]    <= c_PAL1_RST;
            r_pal_q[2]    <= c_PAL2_RST;
            r_pal_q[3]    <= c_PAL3_RST;
        end else begin
            // S0
            r_row0_q      <= row[8:1];
            r_col0_q      <= col[9:1];
            r_vis0_q      <= w_vis0_d;
            r_hs0_q       <= HS;
            r_vs0_q       <= VS;
            r_blank0_q    <= blank_N;
            // S1
            r_tile_addr_q <= w_tile_addr_d;
            r_trow1_q     <= r_row0_q[3:1];
            r_tcol1_q     <= r_col0_q[3:1];
            r_vis1_q      <= r_vis0_q;
            // S2: tile RAM answers the S1 address here
            r_pat_addr_q  <= {tile_data, r_trow1_q};
            r_tcol2_q     <= r_tcol1_q;
            r_vis2_q      <= r_vis1_q;
            // S3: pattern ROM answers the S2 address here
            r_pat3_q      <= pat_data;
            r_px3_q       <= r_tcol2_q;
            r_vis3_q      <= r_vis2_q;
            // S4
            r_code4_q     <= w_code4_d;
            r_vis4_q      <= r_vis3_q;
            // S5: lookup reads the palette before this edge's write lands
            r_rgb_q       <= w_rgb_d;
            r_hs_q        <= w_hs_d;
            r_vs_q        <= w_vs_d;
            r_blank_q     <= w_blank_d;
            for (int i = 0; i < 4; i++) begin
                r_pal_q[i] <= w_pal_d[i];
            end
        end
    end

    assign tile_addr   = r_tile_addr_q;
    assign pat_addr    = r_pat_addr_q;
    assign VGA_R       = r_rgb_q[23:16];
    assign VGA_G       = r_rgb_q[15:8];
    assign VGA_B       = r_rgb_q[7:0];
    assign HS_out      = r_hs_q[LAT-1];
    assign VS_out      = r_vs_q[LAT-1];
    assign blank_N_out = r_blank_q[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_renderer
// Purpose  : Directed self-checking bench for tile_renderer. Models the tile
//            RAM and the pattern ROM. Holds hand-derived expected colours in
//            a 5-deep expectation queue so that every pixel is checked exactly
//            LAT cycles after it is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_renderer;

    localparam int c_LAT = 5;

    logic        CLOCK_100 = 1'b0;
    logic        reset     = 1'b0;
    logic [8:0]  row       = '0;
    logic [9:0]  col       = '0;
    logic        blank_N   = 1'b1;
    logic        HS        = 1'b1;
    logic        VS        = 1'b1;
    logic [10:0] tile_addr;
    logic [7:0]  tile_data;
    logic [10:0] pat_addr;
    logic [15:0] pat_data;
    logic        pal_we    = 1'b0;
    logic [1:0]  pal_idx   = '0;
    logic [23:0] pal_data  = '0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        HS_out, VS_out, blank_N_out;

    logic        rom_ffff  = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] rgb;
        logic        blk;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t q[$];

    tile_renderer #(.LAT(c_LAT), .TILES_X(40)) dut (
        .CLOCK_100   (CLOCK_100),
        .reset       (reset),
        .row         (row),
        .col         (col),
        .blank_N     (blank_N),
        .HS          (HS),
        .VS          (VS),
        .tile_addr   (tile_addr),
        .tile_data   (tile_data),
        .pat_addr    (pat_addr),
        .pat_data    (pat_data),
        .pal_we      (pal_we),
        .pal_idx     (pal_idx),
        .pal_data    (pal_data),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .HS_out      (HS_out),
        .VS_out      (VS_out),
        .blank_N_out (blank_N_out)
    );

    always #5 CLOCK_100 = ~CLOCK_100;

    // Memory models: data is a function of the registered address, so it is
    // ready one cycle after the address appears.
    assign tile_data = 8'h05;
    assign pat_data  = rom_ffff ? 16'hFFFF :
                       (pat_addr[10:3] == 8'h05) ? 16'h1B00 : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_100);
        #1;
    endtask

    // Drive one pixel, record what must appear LAT cycles later, advance one
    // clock, then check the pixel sampled LAT clocks ago.
    task automatic step(input logic [8:0] r, input logic [9:0] c, input logic b,
                        input logic h, input logic v, input logic [23:0] rgb);
        exp_t e;
        row     = r;
        col     = c;
        blank_N = b;
        HS      = h;
        VS      = v;
        e.rgb = rgb; e.blk = b; e.hs = h; e.vs = v;
        q.push_back(e);
        tick();
        if (q.size() == c_LAT + 1) begin
            e = q.pop_front();
            chk("rgb",         {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, e.rgb});
            chk("blank_N_out", {31'd0, blank_N_out},        {31'd0, e.blk});
            chk("HS_out",      {31'd0, HS_out},             {31'd0, e.hs});
            chk("VS_out",      {31'd0, VS_out},             {31'd0, e.vs});
        end
    endtask

    // Colour of pattern 1B00 at screen column c: tile pixels 1,2,3 carry
    // codes 1,2,3 (default palette red, green, blue); the rest carry code 0.
    function automatic logic [23:0] exp_col(input int c);
        case ((c >> 1) & 7)
            1:       return 24'hFF0000;
            2:       return 24'h00FF00;
            3:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic addr_vec(input string tag, input logic [8:0] r, input logic [9:0] c,
                            input logic b, input logic [10:0] exp);
        row = r; col = c; blank_N = b;
        tick();
        tick();
        chk(tag, {21'd0, tile_addr}, {21'd0, exp});
    endtask

    initial begin
        // ---------------- reset and fill ----------------
        row = 9'd0; col = 10'd0; blank_N = 1'b1; HS = 1'b1; VS = 1'b1;
        tick();
        tick();
        chk("rst_rgb",       {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("rst_tile_addr", {21'd0, tile_addr},          32'h0);
        chk("rst_pat_addr",  {21'd0, pat_addr},           32'h0);
        chk("rst_HS_out",    {31'd0, HS_out},             32'h0);
        reset = 1'b1;
        for (int k = 1; k <= c_LAT; k++) begin
            tick();
            chk("fill_HS_out",    {31'd0, HS_out},      32'h0);
            chk("fill_VS_out",    {31'd0, VS_out},      32'h0);
            chk("fill_blank_out", {31'd0, blank_N_out}, 32'h0);
        end
        tick();
        chk("filled_HS_out",    {31'd0, HS_out},      32'h1);
        chk("filled_VS_out",    {31'd0, VS_out},      32'h1);
        chk("filled_blank_out", {31'd0, blank_N_out}, 32'h1);

        // ---------------- address mapping ----------------
        row = 9'd17; col = 10'd35; blank_N = 1'b1;
        tick();
        chk("addr_latency", {21'd0, tile_addr}, 32'd0);
        tick();
        chk("addr_17_35", {21'd0, tile_addr}, 32'd42);
        addr_vec("addr_last",   9'd479, 10'd639, 1'b1, 11'd1199);
        addr_vec("addr_first",  9'd0,   10'd0,   1'b1, 11'd0);
        addr_vec("addr_mid",    9'd100, 10'd200, 1'b1, 11'd252);
        addr_vec("addr_col640", 9'd100, 10'd640, 1'b1, 11'd0);
        addr_vec("addr_row480", 9'd480, 10'd100, 1'b1, 11'd0);
        addr_vec("addr_blank",  9'd17,  10'd35,  1'b0, 11'd0);

        // ---------------- pixel extraction and latency ----------------
        q.delete();
        for (int i = 0; i < c_LAT; i++) step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0);
        for (int i = 0; i < 32; i++) begin
            step(9'd2, 10'(i / 2), 1'b1, logic'(i % 2), logic'(i < 4), exp_col(i / 2));
            if (i >= 2) chk("pat_addr_row2", {21'd0, pat_addr}, {21'd0, 8'h05, 3'd1});
        end
        for (int i = 0; i < c_LAT; i++) step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0);

        // ---------------- blanking ----------------
        rom_ffff = 1'b1;
        q.delete();
        for (int i = 0; i < c_LAT; i++) step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0);
        step(9'd0, 10'd0, 1'b1, 1'b1, 1'b1, 24'h0000FF);
        for (int i = 0; i < c_LAT + 1; i++) step(9'd40, 10'd40, 1'b0, 1'b0, 1'b1, 24'h0);
        rom_ffff = 1'b0;

        // ---------------- palette write collision ----------------
        q.delete();
        for (int i = 0; i < c_LAT; i++) step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0);
        step(9'd2, 10'd2, 1'b1, 1'b1, 1'b1, 24'hFF0000);
        step(9'd2, 10'd2, 1'b1, 1'b1, 1'b1, 24'h123456);
        for (int i = 0; i < 3; i++) step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0);
        // This edge is the one where S5 looks up the first code-1 pixel.
        pal_we = 1'b1; pal_idx = 2'd1; pal_data = 24'h123456;
        step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0);
        pal_we = 1'b0; pal_idx = 2'd0; pal_data = 24'h0;
        for (int i = 0; i < c_LAT; i++) step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0);

        // ---------------- reset mid-frame ----------------
        q.delete();
        for (int i = 0; i < 8; i++) step(9'd2, 10'd2, 1'b1, 1'b1, 1'b1, 24'h123456);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_rgb",       {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("midrst_tile_addr", {21'd0, tile_addr},          32'h0);
        chk("midrst_pat_addr",  {21'd0, pat_addr},           32'h0);
        chk("midrst_HS_out",    {31'd0, HS_out},             32'h0);
        tick();
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) step(9'd2, 10'd2, 1'b1, 1'b1, 1'b1, 24'hFF0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
